// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down counter.
//   DIR_UP / DIR_DOWN   : encoding of the 'up' direction input
//   MODE_WRAP / MODE_SAT: encoding of the SATURATE parameter
package updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: produces one tick every PRESCALE enabled cycles.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   clr    : synchronous clear of the prescale phase (driven by load)
//   enable : advances the prescale phase; phase holds when low
//   tick   : combinational, high on the enabled cycle that completes a period
module counter_prescaler #(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned PWIDTH   = $clog2(PRESCALE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic enable,
    output logic tick
);

    localparam logic [PWIDTH-1:0] LAST = PWIDTH'(PRESCALE - 1);

    logic [PWIDTH-1:0] pre_cnt;
    logic [PWIDTH-1:0] pre_cnt_d;

    // Tick on the last phase of an enabled period; PRESCALE=1 degenerates to enable.
    assign tick = enable & (pre_cnt == LAST);

    // Next phase: clear has priority, then wrap on tick, then advance on enable.
    always_comb begin
        pre_cnt_d = pre_cnt;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
        end else if (enable) begin
            pre_cnt_d = pre_cnt + PWIDTH'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with programmable terminal value, wrap or
// saturate behaviour, parallel load, enable prescaler, a registered
// terminal-count pulse and a sticky overflow flag.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   enable   : count enable (gates the prescaler)
//   up       : direction, 1 = increment, 0 = decrement (sampled on tick)
//   load     : parallel load strobe
//   load_val : value loaded (clamped to MAX_VAL)
//   cnt      : current count, registered
//   tc       : one-cycle pulse on every boundary step, registered
//   ovf      : sticky boundary-crossing flag, cleared by rst or load
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
    parameter int unsigned       SATURATE = 0,
    parameter int unsigned       PRESCALE = 1,
    parameter int unsigned       PWIDTH   = $clog2(PRESCALE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    logic             tick;
    logic             at_max;
    logic             at_zero;
    logic             boundary;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_d;
    logic             ovf_d;

    counter_prescaler #(
        .PRESCALE (PRESCALE),
        .PWIDTH   (PWIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (load),
        .enable (enable),
        .tick   (tick)
    );

    // Boundary detection; compares are explicit so non-power-of-two MAX_VAL wraps correctly.
    assign at_max   = (cnt == MAX_VAL);
    assign at_zero  = (cnt == '0);
    assign boundary = tick & ((up == DIR_UP) ? at_max : at_zero);

    // Load value clamped into the legal range; widened so the compare is never trivially constant.
    assign load_clamped = ({1'b0, load_val} > {1'b0, MAX_VAL}) ? MAX_VAL : load_val;

    // Next-state: load > tick > hold (reset handled in the register).
    always_comb begin
        cnt_d = cnt;
        tc_d  = 1'b0;
        ovf_d = ovf;
        if (load) begin
            cnt_d = load_clamped;
            ovf_d = 1'b0;
        end else if (boundary) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            if (SATURATE == MODE_WRAP) begin
                cnt_d = (up == DIR_UP) ? '0 : MAX_VAL;
            end
        end else if (tick) begin
            cnt_d = (up == DIR_UP) ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_d;
            tc  <= tc_d;
            ovf <= ovf_d;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter across four configurations:
//   dut 0: WIDTH=8, MAX_VAL=9, wrap,     PRESCALE=1
//   dut 1: WIDTH=8, MAX_VAL=9, saturate, PRESCALE=1
//   dut 2: WIDTH=8, MAX_VAL=255, wrap,   PRESCALE=3
//   dut 3: default parameters (32-bit, wrap, PRESCALE=1)
module tb_updown_counter;

    typedef struct {
        int          dut;
        int          step;
        logic [31:0] cnt;
        logic        tc;
        logic        ovf;
    } exp_t;

    logic clk;
    logic        rst_v [4];
    logic        en_v  [4];
    logic        up_v  [4];
    logic        ld_v  [4];
    logic [31:0] lv_v  [4];

    logic [7:0]  cnt_a, cnt_s, cnt_p;
    logic [31:0] cnt_d;
    logic        tc_a, tc_s, tc_p, tc_d;
    logic        ovf_a, ovf_s, ovf_p, ovf_d;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(0), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .up(up_v[0]), .load(ld_v[0]),
        .load_val(lv_v[0][7:0]), .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a));

    updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1), .PRESCALE(1)) u_s (
        .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .up(up_v[1]), .load(ld_v[1]),
        .load_val(lv_v[1][7:0]), .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s));

    updown_counter #(.WIDTH(8), .MAX_VAL(8'd255), .SATURATE(0), .PRESCALE(3)) u_p (
        .clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .up(up_v[2]), .load(ld_v[2]),
        .load_val(lv_v[2][7:0]), .cnt(cnt_p), .tc(tc_p), .ovf(ovf_p));

    updown_counter u_d (
        .clk(clk), .rst(rst_v[3]), .enable(en_v[3]), .up(up_v[3]), .load(ld_v[3]),
        .load_val(lv_v[3]), .cnt(cnt_d), .tc(tc_d), .ovf(ovf_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus on a dut and queue the response expected after the next edge.
    task automatic step(input int d, input logic r, input logic e, input logic u,
                        input logic l, input logic [31:0] lv,
                        input logic [31:0] ec, input logic et, input logic eo);
        exp_t x;
        @(negedge clk);
        rst_v[d] = r;
        en_v[d]  = e;
        up_v[d]  = u;
        ld_v[d]  = l;
        lv_v[d]  = lv;
        step_no++;
        x.dut  = d;
        x.step = step_no;
        x.cnt  = ec;
        x.tc   = et;
        x.ovf  = eo;
        q.push_back(x);
    endtask

    // Monitor: after each edge, compare the oldest expectation with the named dut.
    always @(posedge clk) begin
        exp_t        e;
        logic [31:0] oc;
        logic        ot, oo;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            case (e.dut)
                0:       begin oc = 32'(cnt_a); ot = tc_a; oo = ovf_a; end
                1:       begin oc = 32'(cnt_s); ot = tc_s; oo = ovf_s; end
                2:       begin oc = 32'(cnt_p); ot = tc_p; oo = ovf_p; end
                default: begin oc = cnt_d;      ot = tc_d; oo = ovf_d; end
            endcase
            n_tests++;
            if (oc !== e.cnt || ot !== e.tc || oo !== e.ovf) begin
                n_fail++;
                $display("FAIL dut%0d step%0d: got cnt=%0h tc=%b ovf=%b, expected cnt=%0h tc=%b ovf=%b",
                         e.dut, e.step, oc, ot, oo, e.cnt, e.tc, e.ovf);
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b1; en_v[i] = 1'b0; up_v[i] = 1'b1; ld_v[i] = 1'b0; lv_v[i] = '0;
        end

        // ---- dut 0: wrap, MAX_VAL=9 ----
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++)
            step(0, 0, 1, 1, 0, 0, 32'(i % 10), (i == 10), (i >= 10));
        // load 3 clears ovf, then count down through the wrap
        step(0, 0, 0, 1, 1, 3, 3, 0, 0);
        step(0, 0, 1, 0, 0, 0, 2, 0, 0);
        step(0, 0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 9, 1, 1);
        step(0, 0, 1, 0, 0, 0, 8, 0, 1);
        // oversized load clamps to MAX_VAL and clears ovf
        step(0, 0, 0, 1, 1, 200, 9, 0, 0);
        // load with enable: load wins, then normal step
        step(0, 0, 1, 1, 1, 5, 5, 0, 0);
        step(0, 0, 1, 1, 0, 0, 6, 0, 0);
        // up is ignored while enable is low
        step(0, 0, 0, 0, 0, 0, 6, 0, 0);
        // set ovf, then rst together with load
        step(0, 0, 0, 1, 1, 9, 9, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 1, 1);
        step(0, 1, 1, 1, 1, 7, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);

        // ---- dut 1: saturate, MAX_VAL=9 ----
        step(1, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 8, 8, 0, 0);
        step(1, 0, 1, 1, 0, 0, 9, 0, 0);
        step(1, 0, 1, 1, 0, 0, 9, 1, 1);
        step(1, 0, 1, 1, 0, 0, 9, 1, 1);
        step(1, 0, 1, 1, 0, 0, 9, 1, 1);
        step(1, 0, 1, 0, 0, 0, 8, 0, 1);
        // saturate at zero going down
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);

        // ---- dut 2: PRESCALE=3 ----
        step(2, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            step(2, 0, 1, 1, 0, 0, 32'(i / 3), 0, 0);
        // one enabled cycle, 4-cycle gap, then the step lands 4 cycles late
        step(2, 0, 1, 1, 0, 0, 3, 0, 0);
        for (int i = 0; i < 4; i++)
            step(2, 0, 0, 1, 0, 0, 3, 0, 0);
        step(2, 0, 1, 1, 0, 0, 3, 0, 0);
        step(2, 0, 1, 1, 0, 0, 4, 0, 0);
        // load clears the prescale phase
        step(2, 0, 1, 1, 0, 0, 4, 0, 0);
        step(2, 0, 1, 1, 1, 10, 10, 0, 0);
        step(2, 0, 1, 1, 0, 0, 10, 0, 0);
        step(2, 0, 1, 1, 0, 0, 10, 0, 0);
        step(2, 0, 1, 1, 0, 0, 11, 0, 0);
        // mid-run reset discards the pending phase
        step(2, 0, 1, 1, 0, 0, 11, 0, 0);
        step(2, 0, 1, 1, 0, 0, 11, 0, 0);
        step(2, 1, 1, 1, 0, 0, 0, 0, 0);
        step(2, 0, 1, 1, 0, 0, 0, 0, 0);
        step(2, 0, 1, 1, 0, 0, 0, 0, 0);
        step(2, 0, 1, 1, 0, 0, 1, 0, 0);

        // ---- dut 3: defaults, legacy up-counter sequence ----
        step(3, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            step(3, 0, 1, 1, 0, 0, 32'(i), 0, 0);
        for (int i = 0; i < 10; i++)
            step(3, 0, 0, 1, 0, 0, 3, 0, 0);
        for (int i = 4; i <= 16; i++)
            step(3, 0, 1, 1, 0, 0, 32'(i), 0, 0);
        // full-width wrap both ways
        step(3, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        step(3, 0, 1, 1, 0, 0, 0, 1, 1);
        step(3, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 1, 1);
        step(3, 0, 1, 0, 0, 0, 32'hFFFF_FFFE, 0, 1);

        // let the monitor drain the last expectation
        @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
